// File: rtl/step_sequencer.sv
//----------------------------------------------------------------------------
// step_sequencer : pattern step sequencer with EDIT / PLAY / RAW modes.
// Optional feature macro: STEP_SEQUENCER_SWING_EN (adds swing port).
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module step_sequencer #(
  parameter int STEPS  = 16,
  parameter int TRACKS = 4,
  parameter int DIV_W  = 24,
  localparam int SW    = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  period,
`ifdef STEP_SEQUENCER_SWING_EN
  input  logic [DIV_W-1:0]  swing,
`endif
  input  logic [SW-1:0]     len,
  input  logic              cur_left,
  input  logic              cur_right,
  input  logic [TRACKS-1:0] tgl,
  input  logic              clr,
  input  logic [TRACKS-1:0] raw,
  output logic [SW-1:0]     step_idx,
  output logic [STEPS-1:0]  step_onehot,
  output logic [TRACKS-1:0] cur_pat,
  output logic [TRACKS-1:0] trig,
  output logic              tick
);

  localparam logic [1:0] c_play = 2'd1;
  localparam logic [1:0] c_raw  = 2'd2;

  logic [SW-1:0]     r_step;
  logic [DIV_W-1:0]  r_div;
  logic [TRACKS-1:0] r_pat [STEPS];
  logic [TRACKS-1:0] r_raw_q;
  logic [TRACKS-1:0] r_trig;
  logic              r_tick;
  logic              r_was_play;

  logic              w_play;
  logic              w_raw;
  logic              w_edit;
  logic [SW-1:0]     w_next;
  logic [SW-1:0]     w_prev;
  logic [DIV_W:0]    w_limit;
  logic              w_adv;

  assign w_play = (mode == c_play);
  assign w_raw  = (mode == c_raw);
  assign w_edit = !w_play && !w_raw;

  // ">=" rather than "==" so a len lowered below the position still wraps
  assign w_next = (r_step >= len) ? '0 : r_step + 1'b1;
  assign w_prev = (r_step == '0) ? len : r_step - 1'b1;

`ifdef STEP_SEQUENCER_SWING_EN
  assign w_limit = {1'b0, period} + (w_next[0] ? {1'b0, swing} : '0);
`else
  assign w_limit = {1'b0, period};
`endif

  assign w_adv = r_was_play && ({1'b0, r_div} >= w_limit);

  // r_was_play resets high so a release straight into PLAY runs in-mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step     <= '0;
      r_div      <= '0;
      r_raw_q    <= '0;
      r_trig     <= '0;
      r_tick     <= 1'b0;
      r_was_play <= 1'b1;
      for (int i = 0; i < STEPS; i++) r_pat[i] <= '0;
    end else begin
      r_raw_q    <= raw;
      r_was_play <= w_play;
      r_trig     <= '0;
      r_tick     <= 1'b0;

      if (w_play) begin
        if (!r_was_play) begin
          r_step <= '0;
          r_div  <= '0;
          r_trig <= r_pat[0] | raw;
        end else if (w_adv) begin
          r_div  <= '0;
          r_step <= w_next;
          r_tick <= 1'b1;
          r_trig <= r_pat[w_next] | raw;
        end else begin
          r_div  <= r_div + 1'b1;
        end
      end else if (w_raw) begin
        r_trig <= raw & ~r_raw_q;
      end else if (cur_right && !cur_left) begin
        r_step <= w_next;
      end else if (cur_left && !cur_right) begin
        r_step <= w_prev;
      end

      if (clr) begin
        for (int i = 0; i < STEPS; i++) r_pat[i] <= '0;
      end else if (w_edit) begin
        r_pat[r_step] <= r_pat[r_step] ^ tgl;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < STEPS; g++) begin : g_onehot
      assign step_onehot[g] = (r_step == SW'(g));
    end
  endgenerate

  assign step_idx = r_step;
  assign cur_pat  = r_pat[r_step];
  assign trig     = r_trig;
  assign tick     = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_step_sequencer.sv
//----------------------------------------------------------------------------
// tb_step_sequencer : directed + randomized checks against a behavioural model.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_step_sequencer;

  localparam int STEPS  = 16;
  localparam int TRACKS = 4;
  localparam int DIV_W  = 24;
  localparam int SW     = 4;
`ifdef STEP_SEQUENCER_SWING_EN
  localparam bit SWING_ON = 1'b1;
`else
  localparam bit SWING_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [DIV_W-1:0]  period = '0;
  logic [DIV_W-1:0]  swing = '0;
  logic [SW-1:0]     len = '1;
  logic              cur_left = 1'b0;
  logic              cur_right = 1'b0;
  logic [TRACKS-1:0] tgl = '0;
  logic              clr = 1'b0;
  logic [TRACKS-1:0] raw = '0;
  logic [SW-1:0]     step_idx;
  logic [STEPS-1:0]  step_onehot;
  logic [TRACKS-1:0] cur_pat;
  logic [TRACKS-1:0] trig;
  logic              tick;

  step_sequencer #(.STEPS(STEPS), .TRACKS(TRACKS), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .period      (period),
`ifdef STEP_SEQUENCER_SWING_EN
    .swing       (swing),
`endif
    .len         (len),
    .cur_left    (cur_left),
    .cur_right   (cur_right),
    .tgl         (tgl),
    .clr         (clr),
    .raw         (raw),
    .step_idx    (step_idx),
    .step_onehot (step_onehot),
    .cur_pat     (cur_pat),
    .trig        (trig),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: position, cycles spent in the current step, pattern.
  int m_pat [STEPS];
  int m_pos, m_spent, m_trig, m_rawp;
  bit m_tick, m_in_play;

  always @(posedge clk or negedge rst_n) begin
    int nt, nxt, ivl;
    bit nk, edit;
    if (!rst_n) begin
      foreach (m_pat[i]) m_pat[i] = 0;
      m_pos = 0; m_spent = 0; m_trig = 0; m_tick = 0; m_rawp = 0;
      m_in_play = 1'b1;
    end else begin
      nt = 0; nk = 0;
      edit = (mode == 2'd0) || (mode == 2'd3);
      if (mode == 2'd1) begin
        if (!m_in_play) begin
          m_pos = 0; m_spent = 0; nt = m_pat[0] | int'(raw);
        end else begin
          nxt = (m_pos >= int'(len)) ? 0 : m_pos + 1;
          ivl = int'(period) + 1 + ((nxt % 2 == 1 && SWING_ON) ? int'(swing) : 0);
          m_spent++;
          if (m_spent >= ivl) begin
            m_pos = nxt; m_spent = 0; nk = 1; nt = m_pat[nxt] | int'(raw);
          end
        end
      end else if (mode == 2'd2) begin
        nt = int'(raw) & ~m_rawp & 'hF;
      end
      if (clr) foreach (m_pat[i]) m_pat[i] = 0;
      else if (edit) m_pat[m_pos] = m_pat[m_pos] ^ int'(tgl);
      if (edit && cur_right && !cur_left) m_pos = (m_pos >= int'(len)) ? 0 : m_pos + 1;
      if (edit && cur_left && !cur_right) m_pos = (m_pos == 0) ? int'(len) : m_pos - 1;
      m_in_play = (mode == 2'd1);
      m_rawp = int'(raw);
      m_trig = nt;
      m_tick = nk;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("step_idx", step_idx, m_pos);
      check("step_onehot", step_onehot, 64'd1 << m_pos);
      check("cur_pat", cur_pat, m_pat[m_pos]);
      check("trig", trig, m_trig);
      check("tick", tick, m_tick);
    end
  end

  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < max);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  task automatic pulse_move(input bit r, input bit l, input logic [TRACKS-1:0] t);
    cur_right = r; cur_left = l; tgl = t;
    @(negedge clk);
    cur_right = 1'b0; cur_left = 1'b0; tgl = '0;
  endtask

  initial begin
    int n, cnt, s;
    // reset state
    period = 24'd4;
    repeat (2) @(negedge clk);
    check("rst_step", step_idx, 0);
    check("rst_onehot", step_onehot, 1);
    check("rst_cur_pat", cur_pat, 0);
    check("rst_trig", trig, 0);
    check("rst_tick", tick, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // cursor and toggle
    repeat (3) pulse_move(1, 0, '0);
    pulse_move(0, 0, 4'b0101);
    check("edit_step3", step_idx, 3);
    check("edit_pat3", cur_pat, 4'b0101);
    check("model_pat3", m_pat[3], 5);

    // wrap with len=3
    len = 4'd3;
    pulse_move(1, 0, '0);
    check("wrap_right", step_idx, 0);
    pulse_move(0, 1, '0);
    check("wrap_left", step_idx, 3);
    pulse_move(1, 1, '0);
    check("both_nomove", step_idx, 3);

    // build pattern[0]=0001, pattern[1]=0010 then PLAY
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("clr_pat", cur_pat, 0);
    pulse_move(1, 0, '0);
    pulse_move(1, 0, 4'b0001);
    pulse_move(0, 0, 4'b0010);
    check("pat1", cur_pat, 4'b0010);
    len = 4'd15; period = 24'd4; swing = '0; mode = 2'd1;
    @(negedge clk);
    check("entry_trig", trig, 4'b0001);
    check("entry_step", step_idx, 0);
    check("entry_tick", tick, 0);
    repeat (5) @(negedge clk);
    check("first_tick", tick, 1);
    check("first_trig", trig, 4'b0010);
    check("first_step", step_idx, 1);
    for (int k = 0; k < 3; k++) begin
      wait_tick(50, n);
      check("tick_spacing", n, 5);
    end

    // len lowered below position
    cnt = 0;
    while (step_idx != 4'd9 && cnt < 400) begin @(negedge clk); cnt++; end
    check("reach_step9", step_idx, 9);
    len = 4'd5;
    wait_tick(50, n);
    check("len_wrap", step_idx, 0);

    // RAW edge detect
    mode = 2'd2; raw = '0;
    repeat (2) @(negedge clk);
    s = int'(step_idx);
    raw = 4'b1001;
    @(negedge clk);
    check("raw_trig", trig, 4'b1001);
    cnt = 1;
    repeat (9) begin @(negedge clk); if (trig == 4'b1001) cnt++; end
    check("raw_once", cnt, 1);
    check("raw_step_hold", step_idx, s);
    raw = '0;

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      if ($urandom % 32 == 0) mode = 2'($urandom % 4);
      if ($urandom % 40 == 0) period = 24'($urandom % 6);
      if ($urandom % 40 == 0) swing = 24'($urandom % 4);
      if ($urandom % 64 == 0) len = 4'($urandom % 16);
      if ($urandom % 4 == 0) raw = 4'($urandom);
      cur_left  = ($urandom % 5 == 0);
      cur_right = ($urandom % 5 == 0);
      tgl = ($urandom % 3 == 0) ? 4'($urandom) : 4'd0;
      clr = ($urandom % 97 == 0);
      @(negedge clk);
    end
    cur_left = 0; cur_right = 0; tgl = '0; clr = 0; raw = '0;

    // interval lengths, with and without swing
    mode = 2'd0; @(negedge clk);
    period = 24'd3; swing = 24'd2; len = 4'd15; mode = 2'd1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wait_tick(50, n);
      check("swing_spacing", n, SWING_ON ? ((k % 2 == 0) ? 6 : 4) : 4);
    end

    // asynchronous reset mid-play
    raw = 4'hF;
    wait_tick(50, n);
    check("pre_rst_trig", trig, 4'hF);
    #1 rst_n = 1'b0;
    #1;
    check("async_step", step_idx, 0);
    check("async_onehot", step_onehot, 1);
    check("async_cur_pat", cur_pat, 0);
    check("async_trig", trig, 0);
    check("async_tick", tick, 0);
    raw = '0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(50, n);
    check("post_rst_interval", n, SWING_ON ? 6 : 4);
    check("post_rst_step", step_idx, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 16, number of pattern steps; power of two, 4..64.
REQ-002 SHALL have parameter TRACKS, default 4, number of sample tracks, 1..16.
REQ-003 SHALL have parameter DIV_W, default 24, width of the tempo divider.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port mode  in  2  0=EDIT, 1=PLAY, 2=RAW; 3 behaves as EDIT.
REQ-007 SHALL have port period  in  DIV_W  clk cycles per step minus one.
REQ-008 SHALL have port len  in  SW=clog2(STEPS)  index of last active step.
REQ-009 SHALL have port cur_left, cur_right  in  1 each  single-cycle cursor-move pulses.
REQ-010 SHALL have port tgl  in  TRACKS  single-cycle toggle mask.
REQ-011 SHALL have port clr  in  1  single-cycle clear-pattern pulse.
REQ-012 SHALL have port raw  in  TRACKS  live pad levels.
REQ-013 SHALL have port step_idx  out  SW  current position.
REQ-014 SHALL have port step_onehot  out  STEPS  one-hot decode of step_idx.
REQ-015 SHALL have port cur_pat  out  TRACKS  pattern word at step_idx.
REQ-016 SHALL have port trig  out  TRACKS  registered one-cycle trigger pulses.
REQ-017 SHALL have port tick  out  1  one-cycle pulse on each PLAY step advance.

Function
REQ-018 Pattern SHALL be STEPS words of TRACKS bits; cur_pat SHALL be combinational read at step_idx.
REQ-019 EDIT: cur_right increments, cur_left decrements step_idx; wrap len->0 and 0->len; both pulses together SHALL cause no move.
REQ-020 EDIT: tgl SHALL XOR into the word at the pre-move step_idx in the same cycle as any move.
REQ-021 clr SHALL zero all pattern words in any mode, taking priority over tgl in the same cycle.
REQ-022 tgl SHALL be ignored outside EDIT.
REQ-023 Entering PLAY from any other mode SHALL set step_idx=0 and divider=0, and SHALL pulse trig=pattern[0]|raw on the next cycle.
REQ-024 PLAY: divider counts each cycle; when divider>=period, divider->0, step_idx advances by one, and tick pulses for one cycle.
REQ-025 Advance from step_idx>=len SHALL wrap to 0 (covers len lowered below position).
REQ-026 PLAY: trig SHALL equal pattern[new step]|raw for exactly the cycle after each advance; 0 otherwise.
REQ-027 RAW: trig SHALL pulse per bit one cycle after a 0->1 edge on raw; step_idx holds.
REQ-028 EDIT: trig and tick SHALL be 0.
REQ-029 Leaving PLAY SHALL leave step_idx at its current value; the EDIT cursor resumes from it.
REQ-030 A period change mid-step SHALL take effect at the next compare with no extra step.

Reset
REQ-031 rst_n low SHALL asynchronously clear step_idx, divider, pattern, trig, tick, and the raw edge register to 0; step_onehot=1.
REQ-032 Reset mid-PLAY SHALL discard the pending step; the first cycle after release SHALL be in-mode with divider=0.

Configuration
REQ-033 With STEP_SEQUENCER_SWING_EN defined: port swing  in  DIV_W; an interval that ends on an odd step lasts period+1+swing cycles; even-step intervals last period+1.
REQ-034 Without STEP_SEQUENCER_SWING_EN: no swing port; every interval lasts period+1 cycles.

Verification
REQ-035 Reset, STEPS=16, EDIT, 3x cur_right, tgl=4'b0101 -> pattern[3]=0101, cur_pat=0101, step_idx=3.
REQ-036 len=3, step_idx=3, cur_right -> step_idx=0; cur_left -> step_idx=3; both pulses together -> unchanged.
REQ-037 pattern[0]=0001, pattern[1]=0010, period=4, enter PLAY -> trig=0001 the next cycle; tick and trig=0010 five cycles later; tick every 5 cycles.
REQ-038 PLAY at step 9, len changed to 5 -> next advance step_idx=0.
REQ-039 RAW, raw 0000->1001 held 10 cycles -> trig=1001 for exactly one cycle; step_idx unchanged.
REQ-040 SWING_EN, period=3, swing=2 -> tick spacing alternates 6,4,6,4; rst_n low mid-step -> all outputs 0 immediately.
